// File: rtl/mssd_param.sv
// Framed serial-to-channel demultiplexer: start bit, header (ID, length), payload routed to P[pn].
// Optional even header parity bit enabled by defining MSSD_PARITY_EN.
module mssd_param #(
  parameter int CH_W   = 2,
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 6,
  parameter int UNIT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serIn,
  output logic [NUM_CH-1:0] P,
  output logic [CH_W-1:0]   pn,
  output logic              Vout,
  output logic              error,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);
  localparam int HW  = CH_W + LEN_W;
  localparam int HCW = $clog2(HW);
  localparam int UB  = $clog2(UNIT);
  localparam int PW  = LEN_W + UB;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAR, S_DATA, S_DROP} state_t;

  state_t            state, nxt;
  logic [HCW-1:0]    hcnt;
  logic [HW-2:0]     sh;
  logic [LEN_W-1:0]  len;
  logic [PW-1:0]     pcnt;
  logic              done_nxt;
  logic [HW-1:0]     hdr_full;
  logic [CH_W-1:0]   hdr_id;
  logic [LEN_W-1:0]  hdr_len;
  logic [PW-1:0]     pay_last;
  logic              hdr_last;
  logic              pay_end;
`ifdef MSSD_PARITY_EN
  logic              par_q;
`endif

  assign hdr_full = {sh, serIn};
  assign hdr_id   = hdr_full[HW-1 -: CH_W];
  assign hdr_len  = hdr_full[LEN_W-1:0];
  assign hdr_last = (state == S_HDR) && (hcnt == HCW'(HW - 1));
  // Payload length is L*UNIT bits; PW is wide enough that L at maximum never wraps.
  assign pay_last = {len, {UB{1'b0}}} - PW'(1);
  assign pay_end  = (pcnt == pay_last);

  always_comb begin
    nxt      = state;
    done_nxt = 1'b0;
    case (state)
      S_IDLE: if (!serIn) nxt = S_HDR;
      S_HDR: begin
        if (hdr_last) begin
`ifdef MSSD_PARITY_EN
          nxt = S_PAR;
`else
          if (hdr_len == '0) begin
            nxt      = S_IDLE;
            done_nxt = 1'b1;
          end else if ({1'b0, hdr_id} < (CH_W + 1)'(NUM_CH)) begin
            nxt = S_DATA;
          end else begin
            nxt = S_DROP;
          end
`endif
        end
      end
`ifdef MSSD_PARITY_EN
      S_PAR: begin
        if (serIn != par_q) begin
          nxt = S_DROP;
        end else if (len == '0) begin
          nxt      = S_IDLE;
          done_nxt = 1'b1;
        end else if ({1'b0, pn} < (CH_W + 1)'(NUM_CH)) begin
          nxt = S_DATA;
        end else begin
          nxt = S_DROP;
        end
      end
`endif
      S_DATA: begin
        if (pay_end) begin
          nxt      = S_IDLE;
          done_nxt = 1'b1;
        end
      end
      S_DROP: begin
        // A zero-length frame only lands here on a parity mismatch: drop for one cycle.
        if (pay_end || (len == '0)) begin
          nxt      = S_IDLE;
          done_nxt = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      hcnt       <= '0;
      sh         <= '0;
      pn         <= '0;
      len        <= '0;
      pcnt       <= '0;
      frame_done <= 1'b0;
`ifdef MSSD_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state      <= nxt;
      frame_done <= done_nxt;
      if (state == S_HDR) sh <= hdr_full[HW-2:0];
      if ((state == S_HDR) && !hdr_last) hcnt <= hcnt + 1'b1;
      else                                hcnt <= '0;
      if (hdr_last) begin
        pn  <= hdr_id;
        len <= hdr_len;
`ifdef MSSD_PARITY_EN
        par_q <= ^hdr_full;
`endif
      end
      if ((state == S_DATA) || (state == S_DROP)) pcnt <= pcnt + 1'b1;
      else                                         pcnt <= '0;
    end
  end

  // Vout is a valid-only strobe (no ready): P[pn] carries a payload bit at every rising edge while Vout=1.
  assign Vout      = (state == S_DATA);
  assign error     = (state == S_DROP);
  assign dbg_state = state;

  always_comb begin
    P = '0;
    for (int i = 0; i < NUM_CH; i++)
      P[i] = (state == S_DATA) && (pn == CH_W'(i)) && serIn;
  end
endmodule
